// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: synchronises and debounces NUM_KEYS buttons, classifies press/long/release
// events and queues them through a round-robin arbiter into a valid/ready event FIFO.
module key_scan_ctrl #(
    parameter int NUM_KEYS       = 4,
    parameter int TICK_CYCLES    = 65_000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter bit DEFAULT_VALUE  = 1'b0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_KEYS-1:0]                         ikey,
    output logic                                        ev_valid,
    input  logic                                        ev_ready,
    output logic [(NUM_KEYS>1?$clog2(NUM_KEYS):1)-1:0]  ev_key,
    output logic [1:0]                                  ev_code,
    output logic [NUM_KEYS-1:0]                         key_level,
    output logic                                        ovf,
    input  logic                                        ovf_clr
);
    localparam int KW   = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
    localparam int MAXT = DEBOUNCE_TICKS > LONG_TICKS ? DEBOUNCE_TICKS : LONG_TICKS;
    localparam int CW   = MAXT > 1 ? $clog2(MAXT) : 1;
    localparam int PW   = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int AW   = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] EV_PRESS = 2'b01, EV_LONG = 2'b10, EV_REL = 2'b11;

    typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, HELD, REL_WAIT} state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, active;
    logic [PW-1:0]       presc;
    logic                tick;
    state_t              st [NUM_KEYS];
    state_t              st_n [NUM_KEYS];
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [CW-1:0]       cnt_n [NUM_KEYS];
    logic [1:0]          rcode [NUM_KEYS];
    logic [1:0]          pend_c [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_done, ld_n, raise, pend_v, gnt, occ;
    logic [KW-1:0]       rr, gidx;
    logic                gv, push_ok, pop, full;
    logic [KW-1:0]       mem_k [FIFO_DEPTH];
    logic [1:0]          mem_c [FIFO_DEPTH];
    logic [AW-1:0]       wr, rd;
    logic [NW-1:0]       count;

    assign active   = sync2 ^ {NUM_KEYS{DEFAULT_VALUE}};
    assign tick     = presc == PW'(TICK_CYCLES - 1);
    assign full     = count == NW'(FIFO_DEPTH);
    assign ev_valid = count != '0;
    assign pop      = ev_valid & ev_ready;
    assign push_ok  = ~full | ev_ready;
    assign ev_key   = mem_k[rd];
    assign ev_code  = mem_c[rd];
    // a slot being drained this cycle can accept a new event without loss
    assign occ      = pend_v & ~gnt;

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            st_n[k]  = st[k];
            cnt_n[k] = cnt[k];
            ld_n[k]  = long_done[k];
            raise[k] = 1'b0;
            rcode[k] = EV_PRESS;
            case (st[k])
                IDLE: if (active[k]) begin
                    st_n[k]  = PRESS_WAIT;
                    cnt_n[k] = '0;
                end
                PRESS_WAIT: if (!active[k]) st_n[k] = IDLE;
                else if (cnt[k] == CW'(DEBOUNCE_TICKS - 1)) begin
                    st_n[k]  = PRESSED;
                    cnt_n[k] = '0;
                    ld_n[k]  = 1'b0;
                    raise[k] = 1'b1;
                end else cnt_n[k] = cnt[k] + 1'b1;
                PRESSED: if (!active[k]) begin
                    st_n[k]  = REL_WAIT;
                    cnt_n[k] = '0;
                end else if (cnt[k] == CW'(LONG_TICKS - 1)) begin
                    st_n[k]  = HELD;
                    ld_n[k]  = 1'b1;
                    raise[k] = 1'b1;
                    rcode[k] = EV_LONG;
                end else cnt_n[k] = cnt[k] + 1'b1;
                HELD: if (!active[k]) begin
                    st_n[k]  = REL_WAIT;
                    cnt_n[k] = '0;
                end
                REL_WAIT: if (active[k]) begin
                    st_n[k]  = long_done[k] ? HELD : PRESSED;
                    cnt_n[k] = long_done[k] ? cnt[k] : '0;
                end else if (cnt[k] == CW'(DEBOUNCE_TICKS - 1)) begin
                    st_n[k]  = IDLE;
                    raise[k] = 1'b1;
                    rcode[k] = EV_REL;
                end else cnt_n[k] = cnt[k] + 1'b1;
                default: st_n[k] = IDLE;
            endcase
        end
    end

    always_comb begin
        int j;
        gv   = 1'b0;
        gidx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            j = int'(rr) + i;
            j = j >= NUM_KEYS ? j - NUM_KEYS : j;
            if (!gv && pend_v[j] && push_ok) begin
                gv   = 1'b1;
                gidx = KW'(j);
            end
        end
        gnt = gv ? NUM_KEYS'(1) << gidx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= {NUM_KEYS{DEFAULT_VALUE}};
            sync2     <= {NUM_KEYS{DEFAULT_VALUE}};
            presc     <= '0;
            long_done <= '0;
            key_level <= '0;
            pend_v    <= '0;
            ovf       <= 1'b0;
            rr        <= '0;
            wr        <= '0;
            rd        <= '0;
            count     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                st[k]     <= IDLE;
                cnt[k]    <= '0;
                pend_c[k] <= '0;
            end
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                mem_k[d] <= '0;
                mem_c[d] <= '0;
            end
        end else begin
            sync1 <= ikey;
            sync2 <= sync1;
            presc <= tick ? '0 : presc + 1'b1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (tick) begin
                    st[k]        <= st_n[k];
                    cnt[k]       <= cnt_n[k];
                    long_done[k] <= ld_n[k];
                    key_level[k] <= st_n[k] == PRESSED || st_n[k] == HELD || st_n[k] == REL_WAIT;
                end
                if (gnt[k]) pend_v[k] <= 1'b0;
                if (tick && raise[k] && !occ[k]) begin
                    pend_v[k] <= 1'b1;
                    pend_c[k] <= rcode[k];
                end
            end
            if (tick && |(raise & occ)) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (gv) begin
                mem_k[wr] <= gidx;
                mem_c[wr] <= pend_c[gidx];
                wr        <= wr == AW'(FIFO_DEPTH - 1) ? '0 : wr + 1'b1;
                rr        <= gidx == KW'(NUM_KEYS - 1) ? '0 : gidx + 1'b1;
            end
            if (pop) rd <= rd == AW'(FIFO_DEPTH - 1) ? '0 : rd + 1'b1;
            count <= count + NW'(gv) - NW'(pop);
        end
    end
endmodule
